// File: rtl/dh_sched_pkg.sv
// dh_sched_pkg: shared state type and datapath widths for the DH exponentiation scheduler.
// No ports; imported by dh_exp_scheduler and rr_arbiter2.
package dh_sched_pkg;
   localparam int N_REQ  = 2;
   localparam int BASE_W = 64;
   localparam int EXP_W  = 32;
   localparam int RES_W  = 64;
   typedef enum logic [1:0] {IDLE, BUSY, RESP, DRAIN} state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant, combinational (the parent registers the result).
// Ports: i_req (request per requester), i_last_gnt (index granted last), o_gnt (one-hot grant).
import dh_sched_pkg::*;
module rr_arbiter2 (
   input  logic [N_REQ-1:0] i_req,
   input  logic             i_last_gnt,
   output logic [N_REQ-1:0] o_gnt
);
   // under contention the requester that was not served last wins
   assign o_gnt[0] = i_req[0] & (~i_req[1] | i_last_gnt);
   assign o_gnt[1] = i_req[1] & (~i_req[0] | ~i_last_gnt);
endmodule

// File: rtl/dh_exp_scheduler.sv
// dh_exp_scheduler: shares one modexp engine between two requesters with round-robin grant and timeout.
// Ports: clk/rst (sync, active-low); req_valid/req_base/req_exp in, req_ready out (grant pulse);
// rsp_valid/rsp_result/rsp_err out (response pulse); eng_start/eng_base/eng_exponent out and
// eng_result/eng_done in (level-held engine handshake). All outputs are registered.
import dh_sched_pkg::*;
module dh_exp_scheduler #(
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int CNT_W          = 13
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*BASE_W-1:0] req_base,
   input  logic [N_REQ*EXP_W-1:0]  req_exp,
   output logic [N_REQ-1:0]        req_ready,
   output logic [N_REQ-1:0]        rsp_valid,
   output logic [RES_W-1:0]        rsp_result,
   output logic                    rsp_err,
   output logic                    eng_start,
   output logic [BASE_W-1:0]       eng_base,
   output logic [EXP_W-1:0]        eng_exponent,
   input  logic [RES_W-1:0]        eng_result,
   input  logic                    eng_done
);
   state_t             r_state;
   state_t             w_next;
   logic               r_gnt_id;
   logic               r_last_gnt;
   logic [CNT_W-1:0]   r_cnt;
   logic [RES_W-1:0]   r_res;
   logic               r_err;
   logic [N_REQ-1:0]   w_gnt;
   logic               w_timeout;
   logic [N_REQ-1:0]   w_req_ready;
   logic [N_REQ-1:0]   w_rsp_valid;
   logic               w_eng_start;

   rr_arbiter2 u_arb (
      .i_req      (req_valid),
      .i_last_gnt (r_last_gnt),
      .o_gnt      (w_gnt)
   );

   assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = (|req_valid) ? BUSY : IDLE;
         BUSY:    w_next = (eng_done || w_timeout) ? RESP : BUSY;
         RESP:    w_next = DRAIN;
         DRAIN:   w_next = eng_done ? DRAIN : IDLE;
         default: w_next = IDLE;
      endcase
   end

   // next values of the registered outputs; start is only raised for cycles that stay in BUSY,
   // so it is already low while the FSM sits in RESP
   always_comb begin
      w_req_ready = (r_state == IDLE) ? w_gnt : '0;
      w_eng_start = (r_state == BUSY) && (w_next == BUSY);
      w_rsp_valid = (r_state == RESP) ? (r_gnt_id ? 2'b10 : 2'b01) : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         req_ready    <= '0;
         rsp_valid    <= '0;
         rsp_result   <= '0;
         rsp_err      <= 1'b0;
         eng_start    <= 1'b0;
         eng_base     <= '0;
         eng_exponent <= '0;
         r_cnt        <= '0;
         r_last_gnt   <= 1'b1;
         r_gnt_id     <= 1'b0;
         r_res        <= '0;
         r_err        <= 1'b0;
      end else begin
         req_ready <= w_req_ready;
         rsp_valid <= w_rsp_valid;
         eng_start <= w_eng_start;
         if (r_state == IDLE && |req_valid) begin
            r_gnt_id     <= w_gnt[1];
            eng_base     <= w_gnt[1] ? req_base[2*BASE_W-1:BASE_W] : req_base[BASE_W-1:0];
            eng_exponent <= w_gnt[1] ? req_exp[2*EXP_W-1:EXP_W] : req_exp[EXP_W-1:0];
            r_cnt        <= '0;
         end
         if (r_state == BUSY) begin
            r_cnt <= r_cnt + CNT_W'(1);
            // done wins over a timeout reached on the same cycle
            if (w_next == RESP) begin
               r_res <= eng_done ? eng_result : '0;
               r_err <= ~eng_done;
            end
         end
         if (r_state == RESP) begin
            rsp_result <= r_res;
            rsp_err    <= r_err;
            r_last_gnt <= r_gnt_id;
         end
      end
   end
endmodule

// File: tb/tb_dh_exp_scheduler.sv
// tb_dh_exp_scheduler: randomized and directed checks of the scheduler against a behavioural engine and scoreboard.
module tb_dh_exp_scheduler;
   localparam int T = 16;

   logic         clk = 0;
   logic         rst = 0;
   logic [1:0]   req_valid = 0;
   logic [127:0] req_base = 0;
   logic [63:0]  req_exp = 0;
   logic [1:0]   req_ready, rsp_valid;
   logic [63:0]  rsp_result;
   logic         rsp_err, eng_start;
   logic [63:0]  eng_base;
   logic [31:0]  eng_exponent;
   logic [63:0]  eng_result = 0;
   logic         eng_done = 0;

   int checks = 0;
   int errors = 0;
   int e_delay = 2;
   int e_hold = 0;
   bit rand_mode = 0;

   dh_exp_scheduler #(.TIMEOUT_CYCLES(T), .CNT_W(13)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_base(req_base), .req_exp(req_exp),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_err(rsp_err),
      .eng_start(eng_start), .eng_base(eng_base), .eng_exponent(eng_exponent),
      .eng_result(eng_result), .eng_done(eng_done)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] modpow(input logic [63:0] b, input logic [31:0] e);
      logic [63:0] r = 64'd1;
      for (int i = 31; i >= 0; i--) begin
         r = r * r;
         if (e[i]) r = r * b;
      end
      return r;
   endfunction

   // engine: raises done after e_delay cycles of start (0 = never), keeps it e_hold cycles after start drops
   initial begin
      int cnt = 0;
      int left = 0;
      forever begin
         @(posedge clk);
         #2;
         if (eng_start) begin
            if (cnt == 0 && rand_mode) begin
               e_delay = $urandom_range(1, 18);
               e_hold = $urandom_range(0, 3);
            end
            cnt++;
            if (!eng_done && e_delay != 0 && cnt >= e_delay) begin
               eng_done = 1;
               eng_result = modpow(eng_base, eng_exponent);
               left = e_hold;
            end
         end else begin
            cnt = 0;
            if (eng_done) begin
               if (left > 0) left--;
               else eng_done = 0;
            end
         end
      end
   end

   task automatic do_reset();
      rst = 0;
      req_valid = 0;
      @(negedge clk);
      rst = 1;
      for (int i = 0; i < 20 && eng_done; i++) @(negedge clk);
   endtask

   task automatic wait_ready(output bit ok);
      ok = 0;
      for (int i = 0; i < 30 && !ok; i++) begin
         @(negedge clk);
         ok = |req_ready;
      end
   endtask

   task automatic wait_rsp(output bit ok, output int lat, output bit extra, output bit prev_start);
      ok = 0;
      lat = 0;
      extra = 0;
      prev_start = 0;
      for (int i = 0; i < 60 && !ok; i++) begin
         prev_start = eng_start;
         @(negedge clk);
         lat++;
         ok = |rsp_valid;
         if (|req_ready) extra = 1;
      end
   endtask

   task automatic test_reset();
      rst = 0;
      repeat (2) @(negedge clk);
      checks++; if (req_ready !== 0) begin errors++; $display("FAIL reset req_ready: got %b expected 00", req_ready); end
      checks++; if (rsp_valid !== 0) begin errors++; $display("FAIL reset rsp_valid: got %b expected 00", rsp_valid); end
      checks++; if (rsp_result !== 0) begin errors++; $display("FAIL reset rsp_result: got %0h expected 0", rsp_result); end
      checks++; if (rsp_err !== 0) begin errors++; $display("FAIL reset rsp_err: got %b expected 0", rsp_err); end
      checks++; if (eng_start !== 0) begin errors++; $display("FAIL reset eng_start: got %b expected 0", eng_start); end
      checks++; if (eng_base !== 0) begin errors++; $display("FAIL reset eng_base: got %0h expected 0", eng_base); end
      checks++; if (eng_exponent !== 0) begin errors++; $display("FAIL reset eng_exponent: got %0h expected 0", eng_exponent); end
      rst = 1;
   endtask

   task automatic test_single();
      bit ok, extra, ps;
      int lat;
      e_delay = 4;
      e_hold = 0;
      req_base[63:0] = 5;
      req_exp[31:0] = 3;
      req_valid = 2'b01;
      wait_ready(ok);
      checks++; if (!ok || req_ready !== 2'b01) begin errors++; $display("FAIL single req_ready: got %b expected 01", req_ready); end
      checks++; if (eng_base !== 64'd5 || eng_exponent !== 32'd3) begin errors++; $display("FAIL single operands: got %0d/%0d expected 5/3", eng_base, eng_exponent); end
      req_valid = 0;
      req_base[63:0] = '1;
      req_exp[31:0] = 7;
      wait_rsp(ok, lat, extra, ps);
      checks++; if (!ok || lat != 6) begin errors++; $display("FAIL single latency: got %0d expected 6", lat); end
      checks++; if (rsp_valid !== 2'b01 || rsp_err !== 0) begin errors++; $display("FAIL single rsp: got valid %b err %b expected 01 0", rsp_valid, rsp_err); end
      checks++; if (rsp_result !== 64'd125) begin errors++; $display("FAIL single result: got %0d expected 125", rsp_result); end
      @(negedge clk);
      checks++; if (rsp_valid !== 0 || rsp_result !== 64'd125) begin errors++; $display("FAIL single hold: got valid %b result %0d expected 00 125", rsp_valid, rsp_result); end
   endtask

   task automatic test_contention();
      bit ok, extra, ps;
      int lat;
      logic [1:0] exp_v;
      do_reset();
      e_delay = 2;
      e_hold = 0;
      req_base = {$urandom, $urandom, $urandom, $urandom};
      req_exp = {$urandom, $urandom};
      req_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         exp_v = (k % 2 == 1) ? 2'b10 : 2'b01;
         wait_ready(ok);
         checks++; if (!ok || req_ready !== exp_v) begin errors++; $display("FAIL contention grant %0d: got %b expected %b", k, req_ready, exp_v); end
         wait_rsp(ok, lat, extra, ps);
         checks++; if (!ok || extra || rsp_valid !== exp_v) begin errors++; $display("FAIL contention rsp %0d: got %b extra %b expected %b", k, rsp_valid, extra, exp_v); end
         checks++; if (rsp_result !== modpow(req_base[(k%2)*64 +: 64], req_exp[(k%2)*32 +: 32])) begin errors++; $display("FAIL contention result %0d: got %0h", k, rsp_result); end
      end
      req_valid = 0;
   endtask

   task automatic test_timeout();
      bit ok, extra, ps;
      int lat;
      e_delay = 0;
      req_base[63:0] = 64'd9;
      req_exp[31:0] = 32'd2;
      req_valid = 2'b01;
      wait_ready(ok);
      req_valid = 0;
      wait_rsp(ok, lat, extra, ps);
      checks++; if (!ok || lat != T + 1) begin errors++; $display("FAIL timeout latency: got %0d expected %0d", lat, T + 1); end
      checks++; if (rsp_err !== 1 || rsp_result !== 0) begin errors++; $display("FAIL timeout rsp: got err %b result %0h expected 1 0", rsp_err, rsp_result); end
      checks++; if (ps !== 0) begin errors++; $display("FAIL timeout start in RESP: got %b expected 0", ps); end
   endtask

   task automatic test_collision();
      bit ok, extra, ps;
      int lat;
      for (int d = T - 1; d <= T; d++) begin
         e_delay = d;
         req_base[127:64] = {$urandom, $urandom};
         req_exp[63:32] = $urandom;
         req_valid = 2'b10;
         wait_ready(ok);
         req_valid = 0;
         wait_rsp(ok, lat, extra, ps);
         checks++; if (!ok || rsp_err !== (d >= T)) begin errors++; $display("FAIL collision err d=%0d: got %b expected %b", d, rsp_err, d >= T); end
         checks++; if (rsp_result !== ((d >= T) ? 64'd0 : modpow(req_base[127:64], req_exp[63:32]))) begin errors++; $display("FAIL collision result d=%0d: got %0h", d, rsp_result); end
      end
   endtask

   task automatic test_drain();
      bit ok, extra, ps, fell, early;
      int lat, fall_at, rdy_at;
      e_delay = 2;
      e_hold = 3;
      req_valid = 2'b10;
      wait_ready(ok);
      wait_rsp(ok, lat, extra, ps);
      fell = 0;
      early = 0;
      fall_at = -1;
      rdy_at = -1;
      for (int i = 1; i < 30 && rdy_at < 0; i++) begin
         @(negedge clk);
         if (!fell && !eng_done) begin fell = 1; fall_at = i; end
         if (|req_ready) begin
            rdy_at = i;
            if (!fell || i == fall_at) early = 1;
         end
      end
      checks++; if (early || rdy_at < 0 || rdy_at != fall_at + 2) begin errors++; $display("FAIL drain grant cycle: got %0d expected %0d", rdy_at, fall_at + 2); end
      req_valid = 0;
      e_hold = 0;
      wait_rsp(ok, lat, extra, ps);
   endtask

   task automatic test_reset_mid_busy();
      bit ok, extra, ps;
      int lat;
      e_delay = 2;
      e_hold = 0;
      req_valid = 2'b01;
      wait_ready(ok);
      req_valid = 0;
      wait_rsp(ok, lat, extra, ps);
      e_delay = 0;
      req_valid = 2'b10;
      wait_ready(ok);
      req_valid = 0;
      repeat (3) @(negedge clk);
      rst = 0;
      @(negedge clk);
      rst = 1;
      checks++; if (eng_start !== 0 || rsp_valid !== 0 || req_ready !== 0) begin errors++; $display("FAIL midreset outputs: got start %b rsp %b rdy %b expected 0 00 00", eng_start, rsp_valid, req_ready); end
      req_valid = 2'b11;
      @(negedge clk);
      checks++; if (req_ready !== 2'b01 || rsp_valid !== 0) begin errors++; $display("FAIL midreset regrant: got %b rsp %b expected 01 00", req_ready, rsp_valid); end
      req_valid = 0;
      e_delay = 2;
      wait_rsp(ok, lat, extra, ps);
   endtask

   task automatic test_random();
      bit outstanding = 0;
      bit last = 1;
      int id = 0;
      int ops = 0;
      logic [63:0] eb = 0;
      logic [31:0] ee = 0;
      logic [1:0] v, exp_v;
      logic [63:0] exp_r;
      do_reset();
      rand_mode = 1;
      for (int c = 0; c < 5000 && ops < 40; c++) begin
         @(negedge clk);
         if (|rsp_valid) begin
            exp_v = 2'b01 << id;
            exp_r = (e_delay >= T) ? 64'd0 : modpow(eb, ee);
            checks++; if (!outstanding || rsp_valid !== exp_v) begin errors++; $display("FAIL random rsp_valid: got %b expected %b", rsp_valid, exp_v); end
            checks++; if (rsp_err !== (e_delay >= T) || rsp_result !== exp_r) begin errors++; $display("FAIL random rsp data: got %b/%0h expected %b/%0h", rsp_err, rsp_result, e_delay >= T, exp_r); end
            last = id[0];
            outstanding = 0;
            ops++;
         end
         if (|req_ready) begin
            v = req_valid;
            id = (v == 2'b11) ? int'(!last) : int'(v[1]);
            exp_v = 2'b01 << id;
            eb = req_base[id*64 +: 64];
            ee = req_exp[id*32 +: 32];
            checks++; if (outstanding || v == 0 || req_ready !== exp_v) begin errors++; $display("FAIL random grant: got %b expected %b (valid %b)", req_ready, exp_v, v); end
            checks++; if (eng_base !== eb || eng_exponent !== ee) begin errors++; $display("FAIL random operands: got %0h/%0h expected %0h/%0h", eng_base, eng_exponent, eb, ee); end
            outstanding = 1;
         end
         req_valid = 2'($urandom_range(0, 3));
         req_base = {$urandom, $urandom, $urandom, $urandom};
         req_exp = {$urandom, $urandom};
      end
      checks++; if (ops != 40) begin errors++; $display("FAIL random progress: got %0d ops expected 40", ops); end
      rand_mode = 0;
      req_valid = 0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_timeout();
      test_collision();
      test_drain();
      test_reset_mid_busy();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/dh_exp_scheduler.md
# dh_exp_scheduler

Shares one modular-exponentiation engine between two requesters (party A and party B of the Diffie-Hellman exchange). Each requester submits a base/exponent pair. The scheduler arbitrates round-robin, sequences the engine's level-held start/done handshake, enforces a timeout, and returns a 64-bit result with an error flag to the granted requester. It sits between the key-exchange top level and the single exponentiation instance.

## Interface
- TIMEOUT_CYCLES, 4096, maximum BUSY cycles before the operation is aborted with an error.
- CNT_W, 13, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous, active-low.
- req_valid  in  2  bit i: requester i has an operation pending.
- req_base  in  128  bits [64i+63:64i]: base for requester i.
- req_exp  in  64  bits [32i+31:32i]: exponent for requester i.
- req_ready  out  2  one-hot, single-cycle pulse: requester i is accepted and its operands are latched.
- rsp_valid  out  2  one-hot, single-cycle pulse: response for requester i.
- rsp_result  out  64  result; meaningful only while rsp_valid is nonzero.
- rsp_err  out  1  timeout flag; qualified by rsp_valid.
- eng_start  out  1  engine start; held high for the whole operation.
- eng_base  out  64  latched base.
- eng_exponent  out  32  latched exponent.
- eng_result  in  64  engine result.
- eng_done  in  1  engine completion level.

## Operation
- Reset (rst=0 at a clock edge) forces the following values:
  - state IDLE;
  - req_ready=0, rsp_valid=0, rsp_result=0, rsp_err=0;
  - eng_start=0, eng_base=0, eng_exponent=0;
  - timeout counter=0;
  - last_gnt=1, so requester 0 wins first.
- Reset mid-operation aborts the operation with no response. The engine is released because eng_start drops.
- States:
  - IDLE:
    - if any req_valid bit is set, grant one requester and pulse its req_ready;
    - latch that requester's base/exponent into eng_base/eng_exponent;
    - record gnt_id, clear the counter, go to BUSY.
  - BUSY:
    - eng_start=1 and the counter increments each cycle;
    - if eng_done=1, capture eng_result, set err=0, go to RESP;
    - else if counter==TIMEOUT_CYCLES-1, capture result 0, set err=1, go to RESP.
    - eng_done has priority over timeout on the same cycle.
  - RESP: eng_start=0; pulse rsp_valid[gnt_id] with rsp_result/rsp_err; set last_gnt=gnt_id; go to DRAIN.
  - DRAIN: eng_start=0; wait until eng_done=0, then go to IDLE. This guarantees the engine has cleared its count before the next start.
- Arbitration:
  - exactly one grant at a time;
  - if both requesters are valid, grant the one that is not last_gnt;
  - if one is valid, grant it regardless of last_gnt.
- req_valid is sampled only in IDLE. A requester deasserting req_valid after its grant does not cancel the operation.
- Operands are taken only at the grant edge. Changes on req_base/req_exp afterwards have no effect.
- rsp_result holds its value after the pulse until the next RESP.

## Timing
- Grant: req_ready pulses in the cycle where IDLE sees req_valid; eng_start rises on the next edge.
- Minimum latency from req_ready to rsp_valid is 2 cycles (eng_done already high in the first BUSY cycle).
- Latency is otherwise (BUSY cycles)+1.
- Minimum turnaround between successive grants is 4 cycles: IDLE, BUSY, RESP, DRAIN with eng_done already low.
- Timeout: rsp_valid occurs exactly TIMEOUT_CYCLES+1 cycles after the first BUSY cycle.
- No combinational path from any input to any output; all outputs are registered.

## Structure
- Package dh_sched_pkg holds:
  - the state enum (IDLE, BUSY, RESP, DRAIN);
  - the constants N_REQ=2, BASE_W=64, EXP_W=32, RES_W=64.
- Sub-module rr_arbiter2: 2-bit request plus last_gnt in, one-hot grant out; combinational, registered by the parent.
- Everything else lives in dh_exp_scheduler; target size is about 200 lines of RTL.

## Test plan
- Single request: requester 0 sends base=5, exp=3; the engine model asserts eng_done after 4 cycles with 125. Required: req_ready=01, eng_base=5, eng_exponent=3, rsp_valid=01, rsp_result=125, rsp_err=0.
- Contention: both requesters valid from reset. Required: order 0, 1, 0, 1 over four operations; never two grants outstanding; rsp_valid one-hot each time.
- Timeout: TIMEOUT_CYCLES=16 and the engine never raises done. Required: rsp_valid at cycle 17 of BUSY, rsp_err=1, rsp_result=0, eng_start low in RESP.
- Done/timeout collision: eng_done rises on the same cycle the counter reaches TIMEOUT_CYCLES-1. Required: rsp_err=0 and the engine result is returned.
- Drain hold: the engine keeps eng_done high for 3 cycles after start drops, with requester 1 valid. Required: no req_ready until the cycle after eng_done falls.
- Reset mid-BUSY: rst=0 for one cycle during BUSY. Required: next cycle eng_start=0, state IDLE, no rsp_valid, and requester 0 wins the next grant.
